pack_n_to_vector: RTL

//  Serial-to-parallel packer: accepts one DWIDTH sample per clock and emits a
//  NUM_INPUTS-lane vector in the lane layout avg_n_per_clk/sum_n_per_clk consume.

---
 rtl/pack_n_to_vector_pkg.sv | 19 +
 rtl/pack_n_to_vector.sv | 87 ++++++++
 2 files changed

// File: rtl/pack_n_to_vector_pkg.sv
// Shared lane-layout helpers for the N-lane DSP blocks.
// pack_n_to_vector, sum_n_per_clk and avg_n_per_clk all place lane k at
// [k*DWIDTH +: DWIDTH]. Keeping that rule here means the producer and the
// consumers cannot drift apart.
package pack_n_to_vector_pkg;

    // Returns the LSB offset of lane 'lane' in a packed vector of 'dwidth'-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned dwidth);
        return lane * dwidth;
    endfunction

    // Returns the total width of a packed vector.
    function automatic int unsigned vec_width(input int unsigned lanes,
                                              input int unsigned dwidth);
        return lanes * dwidth;
    endfunction

endpackage

// File: rtl/pack_n_to_vector.sv
// Serial-to-parallel packer: collects one DWIDTH sample per clock into an
// NUM_INPUTS-lane vector and emits it with a one-cycle valid pulse. A flush
// emits a partially filled vector; the unused lanes of that vector read as zero.
module pack_n_to_vector
    import pack_n_to_vector_pkg::*;
#(
    parameter int NUM_INPUTS = 16,
    parameter int DWIDTH     = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DWIDTH-1:0]                i_dat,
    input  logic                             i_dat_valid,
    input  logic                             i_flush,
    output logic [NUM_INPUTS*DWIDTH-1:0]     o_dat_vector,
    output logic                             o_dat_valid,
    output logic [$clog2(NUM_INPUTS):0]      o_fill
);

    localparam int CNTWIDTH  = $clog2(NUM_INPUTS);
    localparam int FILLWIDTH = $clog2(NUM_INPUTS) + 1;
    localparam int VWIDTH    = NUM_INPUTS * DWIDTH;

    logic [CNTWIDTH-1:0]  cnt_q, cnt_d;
    logic [VWIDTH-1:0]    collect_q, collect_d;
    logic [VWIDTH-1:0]    merged;
    logic [VWIDTH-1:0]    out_vec_q, out_vec_d;
    logic                 out_valid_q, out_valid_d;
    logic [FILLWIDTH-1:0] out_fill_q, out_fill_d;
    logic [NUM_INPUTS-1:0] wr_en;
    logic                 full;
    logic                 emit;

    // Lane write enables, and the collect image including this cycle's sample.
    always_comb begin
        wr_en  = '0;
        merged = collect_q;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            wr_en[k] = i_dat_valid && (cnt_q == CNTWIDTH'(k));
            if (wr_en[k]) begin
                merged[lane_lsb(k, DWIDTH) +: DWIDTH] = i_dat;
            end
        end
    end

    // Emit decision and next-state for the counter, collect and output registers.
    // The collect register is cleared on every emit, so lanes beyond the fill
    // point are already zero and a partial vector needs no separate masking.
    always_comb begin
        full        = i_dat_valid && (cnt_q == CNTWIDTH'(NUM_INPUTS - 1));
        emit        = full || (i_flush && ((cnt_q != '0) || i_dat_valid));
        cnt_d       = cnt_q + CNTWIDTH'(i_dat_valid);
        collect_d   = merged;
        out_vec_d   = out_vec_q;
        out_fill_d  = out_fill_q;
        out_valid_d = 1'b0;
        if (emit) begin
            cnt_d       = '0;
            collect_d   = '0;
            out_vec_d   = merged;
            out_fill_d  = FILLWIDTH'(cnt_q) + FILLWIDTH'(i_dat_valid);
            out_valid_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            collect_q   <= '0;
            out_vec_q   <= '0;
            out_fill_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            collect_q   <= collect_d;
            out_vec_q   <= out_vec_d;
            out_fill_q  <= out_fill_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o_dat_vector = out_vec_q;
    assign o_dat_valid  = out_valid_q;
    assign o_fill       = out_fill_q;

endmodule
